// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core.
// Each cycle this block decides whether the pipeline advances, stalls or flushes.
// The sources, in priority order, are:
//   1. data-memory wait states (freeze the whole pipe),
//   2. load-use hazards (one-cycle bubble into EX),
//   3. taken branches resolved in ID (flush IF/ID).
// A wait-timeout FSM traps a hung data memory in a sticky ERROR state.
// Saturating stall and flush counters are provided for debug.
//
// Handshake: dmem_valid_o mirrors mem_req_i while the FSM is not in ERROR.
// The access completes in the cycle that dmem_valid_o and dmem_ready_i are both high.
// While a request is pending, dmem_valid_o stays high and the pipe is frozen.
// When the requester drops mem_req_i before ready arrives, this is treated as completion.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             dmem_valid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;
  logic freeze;

  // Hazard detection; x0 is hardwired zero so it never creates a dependency
  always_comb begin
    mem_stall = mem_req_i & ~dmem_ready_i;
    load_use  = ex_memread_i & (ex_rd_i != 5'd0) &
                ((ex_rd_i == id_rs1_i) | (id_use_rs2_i & (ex_rd_i == id_rs2_i)));
    wait_inc  = wait_q + 1'b1;
  end

  // State, wait counter, sticky error and event counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic; the RUN freeze cycle is the first counted wait cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
          wait_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT: begin
        if (!mem_req_i || dmem_ready_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= TIMEOUT_V) state_d = ST_ERROR;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Pipeline control outputs (Mealy), forced low while reset is asserted
  always_comb begin
    freeze        = (state_q == ST_ERROR) | mem_stall;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    dmem_valid_o  = (state_q != ST_ERROR) & mem_req_i;
    if (freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (load_use) begin
      // a taken branch in this cycle re-resolves once the load has moved on
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (id_branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_hold_o   = 1'b0;
      dmem_valid_o  = 1'b0;
    end
  end

  // Sticky error and saturating event counters
  always_comb begin
    err_d       = err_q | (state_d == ST_ERROR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush_o && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change 1 ns after the rising edge. Outputs are sampled a further 1 ns later.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs2, ex_memread, br_taken, mem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, dmem_valid, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs2_i(id_use_rs2),
    .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .id_branch_taken_i(br_taken),
    .mem_req_i(mem_req), .dmem_ready_i(dmem_ready),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .pipe_hold_o(pipe_hold), .dmem_valid_o(dmem_valid),
    .err_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic memrd, input logic [4:0] rd, input logic br,
                       input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = use2;
    ex_memread = memrd; ex_rd = rd; br_taken = br;
    mem_req = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_pipe(input string tag, input logic pc, input logic iw, input logic fl,
                            input logic bub, input logic hold);
    check({tag, ".pc_write"}, pc_write, pc);
    check({tag, ".ifid_write"}, ifid_write, iw);
    check({tag, ".ifid_flush"}, ifid_flush, fl);
    check({tag, ".idex_bubble"}, idex_bubble, bub);
    check({tag, ".pipe_hold"}, pipe_hold, hold);
  endtask

  initial begin
    // T1 reset: hold for 3 cycles with a pending request on the inputs
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_pipe("t1_rst", 0, 0, 0, 0, 0);
    check("t1_rst.dmem_valid", dmem_valid, 0);
    check("t1_rst.err", err, 0);
    check("t1_rst.stall_cnt", stall_cnt, 0);
    check("t1_rst.flush_cnt", flush_cnt, 0);
    check("t1_rst.state", dbg_state, S_RUN);
    idle();
    rst_n = 1'b1;
    #1;
    check_pipe("t1_rel", 1, 1, 0, 0, 0);
    step();
    check("t1_rel.stall_cnt", stall_cnt, 0);

    // T2 load-use via rs2, then no-stall variants
    drive(5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check_pipe("t2_rs2", 0, 0, 0, 1, 0);
    step();
    idle();
    check("t2_rs2.stall_cnt", stall_cnt, 1);
    check("t2_after.pc_write", pc_write, 1);
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check_pipe("t2_nouse2", 1, 1, 0, 0, 0);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check_pipe("t2_x0", 1, 1, 0, 0, 0);
    step();
    check("t2_nostall.stall_cnt", stall_cnt, 1);
    drive(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    check_pipe("t2_rs1", 0, 0, 0, 1, 0);
    step();
    idle();
    check("t2_rs1.stall_cnt", stall_cnt, 2);

    // T3 branch flush, then branch masked by load-use
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check_pipe("t3_br", 1, 1, 1, 0, 0);
    step();
    check("t3_br.flush_cnt", flush_cnt, 1);
    drive(5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check_pipe("t3_br_lu", 0, 0, 0, 1, 0);
    step();
    idle();
    check("t3_br_lu.flush_cnt", flush_cnt, 1);
    check("t3_br_lu.stall_cnt", stall_cnt, 3);

    // T4 three wait cycles then ready
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_pipe($sformatf("t4_wait%0d", i), 0, 0, 0, 0, 1);
      check($sformatf("t4_wait%0d.dmem_valid", i), dmem_valid, 1);
      check($sformatf("t4_wait%0d.state", i), dbg_state, (i == 0) ? S_RUN : S_WAIT);
      step();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check_pipe("t4_ready", 1, 1, 0, 0, 0);
    check("t4_ready.dmem_valid", dmem_valid, 1);
    step();
    idle();
    check("t4_done.stall_cnt", stall_cnt, 3);
    check("t4_done.state", dbg_state, S_RUN);

    // request withdrawn mid-wait counts as completion, with load-use still applied
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    check_pipe("t4_drop", 0, 0, 0, 1, 0);
    check("t4_drop.dmem_valid", dmem_valid, 0);
    step();
    idle();
    check("t4_drop.state", dbg_state, S_RUN);

    // reset asserted mid-wait drops the strobe at once
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    check("t4_midrst.pre_state", dbg_state, S_WAIT);
    rst_n = 1'b0;
    #1;
    check("t4_midrst.dmem_valid", dmem_valid, 0);
    check("t4_midrst.state", dbg_state, S_RUN);
    check("t4_midrst.hold", pipe_hold, 0);

    // T5 timeout into ERROR
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    check("t5_w3.state", dbg_state, S_WAIT);
    check("t5_w3.err", err, 0);
    check("t5_w3.dmem_valid", dmem_valid, 1);
    step();
    check("t5_err.state", dbg_state, S_ERR);
    check("t5_err.err", err, 1);
    check("t5_err.dmem_valid", dmem_valid, 0);
    check_pipe("t5_err", 0, 0, 0, 0, 1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("t5_sticky.err", err, 1);
    check("t5_sticky.state", dbg_state, S_ERR);
    check("t5_sticky.hold", pipe_hold, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst.err", err, 0);
    check("t5_rst.dmem_valid", dmem_valid, 0);
    rst_n = 1'b1;
    #1;
    check("t5_rel.state", dbg_state, S_RUN);
    check("t5_rel.pc_write", pc_write, 1);
    check("t5_rel.dmem_valid", dmem_valid, 1);

    // T6 stall counter saturation
    do_reset();
    drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    repeat (14) step();
    check("t6_14.stall_cnt", stall_cnt, 14);
    repeat (6) step();
    check("t6_20.stall_cnt", stall_cnt, 15);
    check("t6_20.flush_cnt", flush_cnt, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
